// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared encodings for the video RAM arbiter
// Purpose: FSM state and slot-owner encodings, default RAM latency and
//          slot counter width used by vram_arbiter.
// Ports:   none (package).
package vram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arbState_t;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  // Cycles from mem_en to mem_rdata valid; legal range 1..15.
  localparam int DEFAULT_MEM_LAT = 2;

  // Slot counter holds MEM_LAT at most, so 4 bits cover the legal range.
  localparam int CNT_W = 4;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter, display fetch over CPU
// Purpose: shares one video RAM between the display fetch path and the CPU.
//          Display fetches have strict priority; CPU accesses fill idle slots
//          through a req/ack handshake. Each access occupies MEM_LAT+1 cycles.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   vid_req, vid_addr           one-cycle fetch request and its address
//   vid_valid, vid_data         fetch-complete pulse and held fetched byte
//   vid_overrun                 sticky: request arrived while one was pending
//   cpu_req/we/addr/wdata       level request, held until cpu_ack
//   cpu_ack, cpu_rdata          completion pulse and held read data
//   mem_en/we/addr/wdata        RAM strobe and held access controls
//   mem_rdata                   RAM read data, valid MEM_LAT cycles after mem_en
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

  arbState_t         state;
  arbState_t         nextState;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  nextCnt;
  owner_t            owner;

  logic              vidPend;
  logic [ADDR_W-1:0] pendAddr;

  logic              vidCand;
  logic              cpuCand;
  logic              cpuInFlight;
  logic              arbSlot;
  logic              slotDone;
  logic              grantVid;
  logic              grantCpu;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Arbitration and next-state logic.
  always_comb begin
    vidCand     = vid_req | vidPend;
    cpuInFlight = (state == ST_ACCESS) && (owner == OWN_CPU);
    // Blocking on cpu_ack keeps a still-high cpu_req from being served twice
    // in the cycle right after its completion.
    cpuCand     = cpu_req && !cpuInFlight && !cpu_ack;
    arbSlot     = (state == ST_IDLE) || (cnt == '0);
    slotDone    = (state == ST_ACCESS) && (cnt == '0);
    grantVid    = arbSlot && vidCand;
    grantCpu    = arbSlot && !vidCand && cpuCand;

    nextState = state;
    nextCnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grantVid || grantCpu) begin
          nextState = ST_ACCESS;
          nextCnt   = LAT_CNT;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          // Last slot cycle doubles as the next arbitration cycle, so
          // back-to-back slots have no gap.
          if (grantVid || grantCpu) begin
            nextState = ST_ACCESS;
            nextCnt   = LAT_CNT;
          end else begin
            nextState = ST_IDLE;
          end
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Datapath: RAM controls, pending video request, completion outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner       <= OWN_VID;
      vidPend     <= 1'b0;
      pendAddr    <= '0;
      vid_valid   <= 1'b0;
      vid_data    <= '0;
      vid_overrun <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_en <= grantVid || grantCpu;

      if (grantVid) begin
        owner    <= OWN_VID;
        mem_we   <= 1'b0;
        // A request arriving in the arbitration cycle goes straight to the
        // bus; it is also the newest address if one was pending.
        mem_addr <= vid_req ? vid_addr : pendAddr;
      end else if (grantCpu) begin
        owner     <= OWN_CPU;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end

      if (vid_req && !grantVid) begin
        vidPend  <= 1'b1;
        pendAddr <= vid_addr;
      end else if (grantVid) begin
        vidPend <= 1'b0;
      end

      if (vid_req && vidPend) begin
        vid_overrun <= 1'b1;
      end

      // mem_we still describes the finishing slot here; a new grant in the
      // same cycle only updates it at this edge.
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      if (slotDone) begin
        if (owner == OWN_VID) begin
          vid_data  <= mem_rdata;
          vid_valid <= 1'b1;
        end else begin
          cpu_ack <= 1'b1;
          if (!mem_we) begin
            cpu_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int NV = 40;
  localparam int NC = 24;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          vid_overrun;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int nChecks = 0;
  int nPass = 0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
    .clk(clk), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
    .vid_data(vid_data), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: data only appears exactly two cycles after the strobe.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [1:0]    vPipe = '0;
  logic [AW-1:0] aPipe0 = '0;
  logic [AW-1:0] aPipe1 = '0;
  logic          preWe = 1'b0;
  logic [AW-1:0] preAddr = '0;
  logic [DW-1:0] preData = '0;

  always @(posedge clk) begin
    vPipe  <= {vPipe[0], mem_en};
    aPipe0 <= mem_addr;
    aPipe1 <= aPipe0;
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    else if (preWe) ram[preAddr] <= preData;
  end

  assign mem_rdata = vPipe[1] ? ram[aPipe1] : '0;

  int ackCount = 0;
  int vvCount = 0;
  int enCount = 0;
  always @(posedge clk) begin
    if (cpu_ack) ackCount++;
    if (vid_valid) vvCount++;
    if (mem_en) enCount++;
  end

  int vidQ [$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    preAddr = a;
    preData = d;
    preWe = 1'b1;
    model[a] = d;
    step();
    preWe = 1'b0;
  endtask

  function automatic logic [DW-1:0] vidByte(input int i);
    return DW'(i * 7 + 3);
  endfunction

  task automatic cpuAccess(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output logic acked);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    acked = 1'b0;
    for (int i = 0; i < 40 && !acked; i++) begin
      step();
      if (cpu_ack) acked = 1'b1;
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic acked;
    int ackBase, vvBase, enBase;

    // Reset window also used to preload RAM.
    step();
    checkEq("rst mem_en", mem_en, 0);
    checkEq("rst vid_valid", vid_valid, 0);
    checkEq("rst cpu_ack", cpu_ack, 0);
    checkEq("rst mem_addr", mem_addr, 0);
    checkEq("rst overrun", vid_overrun, 0);
    preload(13'h0123, 8'h5A);
    preload(13'h0200, 8'h3C);
    preload(13'h1F00, 8'hC3);
    preload(13'h0401, 8'h77);
    preload(13'h0010, 8'h99);
    preload(13'h0500, 8'h11);
    preload(13'h0501, 8'h22);
    preload(13'h0502, 8'hE1);
    for (int i = 0; i < 32; i++) preload(AW'(13'h1800 + i), vidByte(i));
    for (int i = 0; i < 16; i++) preload(AW'(13'h0800 + i), DW'(8'h40 + i));
    resetn = 1'b1;
    step();

    // 1: idle bus video fetch.
    vid_req = 1'b1; vid_addr = 13'h0123;
    step(); vid_req = 1'b0;
    checkEq("t1 mem_en c1", mem_en, 1);
    checkEq("t1 mem_addr c1", mem_addr, 13'h0123);
    checkEq("t1 mem_we c1", mem_we, 0);
    step();
    checkEq("t1 mem_en c2", mem_en, 0);
    step();
    checkEq("t1 vid_valid c3", vid_valid, 0);
    step();
    checkEq("t1 vid_valid c4", vid_valid, 1);
    checkEq("t1 vid_data c4", vid_data, 8'h5A);
    step();
    checkEq("t1 vid_valid c5", vid_valid, 0);
    checkEq("t1 vid_data held", vid_data, 8'h5A);
    step();

    // 2: simultaneous video and CPU read; video wins.
    vid_req = 1'b1; vid_addr = 13'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1F00;
    step(); vid_req = 1'b0;
    checkEq("t2 vid mem_addr c1", mem_addr, 13'h0200);
    step(); step(); step();
    checkEq("t2 vid_valid c4", vid_valid, 1);
    checkEq("t2 vid_data c4", vid_data, 8'h3C);
    checkEq("t2 cpu mem_en c4", mem_en, 1);
    checkEq("t2 cpu mem_addr c4", mem_addr, 13'h1F00);
    step(); step();
    checkEq("t2 cpu_ack c6", cpu_ack, 0);
    step();
    checkEq("t2 cpu_ack c7", cpu_ack, 1);
    checkEq("t2 cpu_rdata c7", cpu_rdata, 8'hC3);
    cpu_req = 1'b0;
    step();
    checkEq("t2 no reissue c8", mem_en, 0);
    checkEq("t2 cpu_ack c8", cpu_ack, 0);
    step();

    // 3: CPU write then queued video fetch.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_wdata = 8'hA5;
    step();
    checkEq("t3 mem_en c1", mem_en, 1);
    checkEq("t3 mem_we c1", mem_we, 1);
    checkEq("t3 mem_addr c1", mem_addr, 13'h0400);
    checkEq("t3 mem_wdata c1", mem_wdata, 8'hA5);
    vid_req = 1'b1; vid_addr = 13'h0401;
    step(); vid_req = 1'b0;
    step(); step();
    checkEq("t3 vid mem_en c4", mem_en, 1);
    checkEq("t3 vid mem_addr c4", mem_addr, 13'h0401);
    checkEq("t3 vid mem_we c4", mem_we, 0);
    checkEq("t3 cpu_ack c4", cpu_ack, 1);
    checkEq("t3 rdata kept", cpu_rdata, 8'hC3);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(); step(); step();
    checkEq("t3 vid_valid c7", vid_valid, 1);
    checkEq("t3 vid_data c7", vid_data, 8'h77);
    checkEq("t3 overrun", vid_overrun, 0);
    step();
    cpuAccess(1'b0, 13'h0400, 8'h00, rd, acked);
    checkEq("t3 readback ack", acked, 1);
    checkEq("t3 readback data", rd, 8'hA5);
    step(); step();

    // 4: overrun while a CPU slot holds the bus.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    step();
    checkEq("t4 cpu mem_addr c1", mem_addr, 13'h0010);
    vid_req = 1'b1; vid_addr = 13'h0500;
    step();
    checkEq("t4 overrun c2", vid_overrun, 0);
    vid_addr = 13'h0501;
    step();
    checkEq("t4 overrun c3", vid_overrun, 1);
    vid_addr = 13'h0502;
    step(); vid_req = 1'b0;
    checkEq("t4 cpu_ack c4", cpu_ack, 1);
    checkEq("t4 cpu_rdata c4", cpu_rdata, 8'h99);
    checkEq("t4 vid mem_addr c4", mem_addr, 13'h0502);
    cpu_req = 1'b0;
    step(); step(); step();
    checkEq("t4 vid_valid c7", vid_valid, 1);
    checkEq("t4 vid_data c7", vid_data, 8'hE1);
    checkEq("t4 no stale fetch c7", mem_en, 0);
    step();

    // 5: reset in the middle of a CPU slot.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    step();
    checkEq("t5 issue c1", mem_en, 1);
    step();
    #1 resetn = 1'b0;
    #1;
    checkEq("t5 rst mem_en", mem_en, 0);
    checkEq("t5 rst mem_addr", mem_addr, 0);
    checkEq("t5 rst overrun", vid_overrun, 0);
    checkEq("t5 rst cpu_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    ackBase = ackCount; vvBase = vvCount; enBase = enCount;
    step(); step();
    resetn = 1'b1;
    repeat (6) step();
    checkEq("t5 no ack", ackCount - ackBase, 0);
    checkEq("t5 no vid_valid", vvCount - vvBase, 0);
    checkEq("t5 no mem_en", enCount - enBase, 0);

    // 6: display fetch every 8 cycles with random CPU traffic.
    ackBase = ackCount; vvBase = vvCount;
    fork
      begin
        for (int k = 0; k < NV; k++) begin
          vid_addr = AW'(13'h1800 + (k % 32));
          vid_req = 1'b1;
          vidQ.push_back(k % 32);
          step();
          vid_req = 1'b0;
          repeat (7) step();
        end
      end
      begin
        for (int j = 0; j < NC; j++) begin
          logic we;
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          logic [DW-1:0] r;
          logic ok;
          we = 1'($urandom_range(0, 1));
          a = AW'(13'h0800 + $urandom_range(0, 15));
          d = DW'($urandom_range(0, 255));
          cpuAccess(we, a, d, r, ok);
          checkEq("t6 cpu ack", ok, 1);
          if (ok && !we) checkEq("t6 cpu rdata", r, model[a]);
          if (ok && we) model[a] = d;
          repeat ($urandom_range(1, 3)) step();
        end
      end
      begin
        for (int c = 0; c < NV * 8 + 20; c++) begin
          step();
          if (vid_valid) begin
            checkEq("t6 vid expected", vidQ.size() > 0, 1);
            if (vidQ.size() > 0) checkEq("t6 vid_data", vid_data, vidByte(vidQ.pop_front()));
          end
        end
      end
    join
    repeat (10) step();
    checkEq("t6 ack count", ackCount - ackBase, NC);
    checkEq("t6 vid_valid count", vvCount - vvBase, NV);
    checkEq("t6 overrun", vid_overrun, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
